// File: rtl/control_unit.sv
// control_unit: multicycle fetch/decode/execute FSM for the 16-bit core.
// Drives ALU selects, memory requests and regfile strobes; resolves branches.
module control_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        alu_zero,
  input  logic        alu_neg,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  alu_op,
  output logic        alu_a_sel,
  output logic [2:0]  alu_b_sel,
  output logic        pc_we,
  output logic        ir_we,
  output logic [3:0]  rf_ra,
  output logic [3:0]  rf_rb,
  output logic [3:0]  rf_wa,
  output logic        rf_we,
  output logic        rf_wd_sel,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_PC_INC,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_MEM_ADDR,
    S_MEM,
    S_WB_MEM,
    S_BR_TEST,
    S_BR_TAKE,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_LUI = 4'b0101;

  localparam logic [2:0] B_REG  = 3'd0;
  localparam logic [2:0] B_ONE  = 3'd1;
  localparam logic [2:0] B_SX8  = 3'd3;
  localparam logic [2:0] B_HI8  = 3'd4;
  localparam logic [2:0] B_SX4  = 3'd5;

  state_t      state;
  state_t      state_nx;
  logic [15:0] ir;

  logic [3:0] op;
  logic [3:0] rd;
  logic [3:0] rs;
  logic [3:0] rt;

  assign op = ir[15:12];
  assign rd = ir[11:8];
  assign rs = ir[7:4];
  assign rt = ir[3:0];

  logic is_r;
  logic is_lui;
  logic is_addi;
  logic is_lw;
  logic is_sw;
  logic is_bz;
  logic is_bn;
  logic is_jmp;
  logic is_ill;
  logic taken;

  assign is_r    = (op <= 4'h4);
  assign is_lui  = (op == 4'h5);
  assign is_addi = (op == 4'h6);
  assign is_lw   = (op == 4'h7);
  assign is_sw   = (op == 4'h8);
  assign is_bz   = (op == 4'h9);
  assign is_bn   = (op == 4'hA);
  assign is_jmp  = (op == 4'hB);
  assign is_ill  = (op >= 4'hC) && (op <= 4'hE);
  assign taken   = (is_bz & alu_zero) | (is_bn & alu_neg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      state <= state_nx;
      if (state == S_FETCH && imem_ready)
        ir <= instr;
    end
  end

  always_comb begin
    rf_wa = rd;
    rf_ra = '0;
    rf_rb = '0;
    unique case (1'b1)
      is_r | is_lw | is_sw:    rf_ra = rs;
      is_addi | is_bz | is_bn: rf_ra = rd;
      default:                 rf_ra = '0;
    endcase
    unique case (1'b1)
      is_r:                    rf_rb = rt;
      is_sw | is_bz | is_bn:   rf_rb = rd;
      default:                 rf_rb = '0;
    endcase
  end

  always_comb begin
    state_nx  = state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    alu_op    = OP_ADD;
    alu_a_sel = 1'b0;
    alu_b_sel = B_REG;
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    rf_we     = 1'b0;
    rf_wd_sel = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    unique case (state)
      S_IDLE: state_nx = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we    = 1'b1;
          state_nx = S_PC_INC;
        end
      end
      S_PC_INC: begin
        alu_a_sel = 1'b1;
        alu_b_sel = B_ONE;
        pc_we     = 1'b1;
        state_nx  = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          is_r | is_lui | is_addi: state_nx = S_EXEC;
          is_lw | is_sw:           state_nx = S_MEM_ADDR;
          is_bz | is_bn:           state_nx = S_BR_TEST;
          is_jmp:                  state_nx = S_BR_TAKE;
          default:                 state_nx = S_HALT;
        endcase
      end
      S_EXEC: begin
        unique case (1'b1)
          is_lui: begin
            alu_op    = OP_LUI;
            alu_b_sel = B_HI8;
          end
          is_addi: alu_b_sel = B_SX8;
          default: alu_op = op;
        endcase
        state_nx = S_WB;
      end
      S_WB: begin
        rf_we    = 1'b1;
        state_nx = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_b_sel = B_SX4;
        state_nx  = S_MEM;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        if (dmem_ready)
          state_nx = is_lw ? S_WB_MEM : S_FETCH;
      end
      S_WB_MEM: begin
        rf_we     = 1'b1;
        rf_wd_sel = 1'b1;
        state_nx  = S_FETCH;
      end
      S_BR_TEST: begin
        alu_op   = OP_AND;
        state_nx = taken ? S_BR_TAKE : S_FETCH;
      end
      S_BR_TAKE: begin
        alu_a_sel = 1'b1;
        alu_b_sel = B_SX8;
        pc_we     = 1'b1;
        state_nx  = S_FETCH;
      end
      S_HALT: begin
        halted  = 1'b1;
        illegal = is_ill;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multicycle control state machine that drives the 16-bit ALU from the opposite side of its interface: it fetches and decodes 16-bit instructions, issues `alu_op` and operand selects, and consumes the ALU `zero`/`neg` flags to resolve branches. It sits between instruction/data memory, the register file and the ALU datapath. It holds its own instruction copy and steps each instruction through fetch, execute, memory and writeback states.

## Interface
Parameters: none. Instruction fields are fixed: op=[15:12], rd=[11:8], rs=[7:4], rt=[3:0], imm8=[7:0], imm4=[3:0].

- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr  in  16  instruction memory data, valid when imem_ready=1
- imem_ready  in  1  instruction fetch complete
- dmem_ready  in  1  data access complete; load data is captured by the datapath on this cycle
- alu_zero  in  1  ALU zero flag (combinational)
- alu_neg  in  1  ALU negative flag (combinational)
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data access request
- dmem_we  out  1  data store (qualifies dmem_req)
- alu_op  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLL, 0101 LUI/pass-B
- alu_a_sel  out  1  0 = regfile port A, 1 = PC
- alu_b_sel  out  3  0 = regfile port B, 1 = const 1, 2 = zext imm8, 3 = sext imm8, 4 = imm8<<8, 5 = sext imm4
- pc_we  out  1  PC <= ALU result this edge
- ir_we  out  1  datapath IR load strobe
- rf_ra  out  4  register file read address A
- rf_rb  out  4  register file read address B
- rf_wa  out  4  register file write address
- rf_we  out  1  register file write enable
- rf_wd_sel  out  1  0 = ALU result register, 1 = load data
- halted  out  1  core stopped
- illegal  out  1  stopped on an undefined opcode

## Operation
- ISA:
  - op 0-4: R-type, rd = rs op rt.
  - 5 LUI: rd = imm8<<8.
  - 6 ADDI: rd = rd + sext(imm8).
  - 7 LW: rd = M[rs + sext(imm4)].
  - 8 SW: M[rs + sext(imm4)] = rd.
  - 9 BZ: if rd==0, PC += sext(imm8).
  - A BN: if rd<0, PC += sext(imm8).
  - B JMP: PC += sext(imm8).
  - F HALT.
  - C-E illegal.
- Branch offsets are relative to the already-incremented PC. All arithmetic is 16-bit modulo; there is no overflow detection.
- Register addresses are always driven from the latched instruction:
  - rf_ra = rs for op 0-4 and 7-8; rd for op 6, 9, A.
  - rf_rb = rt for op 0-4; rd for op 8-A.
  - rf_wa = rd.
- Outputs are Moore-style (decoded from state plus latched instruction). Any output not listed for a state is 0.
- States and transitions:
  - IDLE: reset state. Next is FETCH.
  - FETCH: imem_req=1 until imem_ready. On the ready cycle, ir_we=1, the internal instruction register loads, and next is PC_INC.
  - PC_INC: alu_a_sel=1, alu_b_sel=1, ADD, pc_we=1. Next is DECODE.
  - DECODE: op 0-6 → EXEC; 7-8 → MEM_ADDR; 9/A → BR_TEST; B → BR_TAKE; F → HALT; C-E → HALT with illegal set.
  - EXEC: op 0-4 uses alu_op=op, b_sel=0. LUI uses 0101, b_sel=4. ADDI uses ADD, b_sel=3. Next is WB.
  - WB: rf_we=1, rf_wd_sel=0. Next is FETCH.
  - MEM_ADDR: ADD, b_sel=5. Next is MEM.
  - MEM: dmem_req=1, dmem_we=(op==8), held until dmem_ready. On ready: LW → WB_MEM, SW → FETCH.
  - WB_MEM: rf_we=1, rf_wd_sel=1. Next is FETCH.
  - BR_TEST: alu_op=AND, b_sel=0 (rd & rd). Taken = (BZ & alu_zero) | (BN & alu_neg). Taken → BR_TAKE, else → FETCH.
  - BR_TAKE: alu_a_sel=1, b_sel=3, ADD, pc_we=1. Next is FETCH.
  - HALT: terminal. halted=1 and no requests are issued until reset.
- A request, once raised, stays high until its ready arrives; there is no abort.
- imem_ready outside FETCH and dmem_ready outside MEM are ignored.

## Timing
- Reset: rst_n low forces state IDLE immediately (asynchronously). All outputs go to 0, including alu_op=0000 (ADD). halted and illegal clear.
- After release, the first edge enters IDLE→FETCH, so imem_req rises one cycle after the first post-reset edge.
- Reset asserted mid-MEM or mid-FETCH drops the request the same cycle. No write or PC update completes.
- Cycle counts with zero-wait memory (ready in the first request cycle), FETCH through the final state:
  - R/LUI/ADDI: 5
  - LW: 6
  - SW: 5
  - branch not taken: 4
  - branch taken: 5
  - JMP: 4
- Each wait cycle adds exactly one cycle.
- alu_zero/alu_neg are sampled only at the BR_TEST edge. pc_we asserts at most twice per instruction.

## Test plan
- Reset with a LW in MEM, dmem_req=1 → all outputs 0 within the reset cycle. After release: IDLE, then imem_req=1 on the second cycle.
- ADD 0x0312, imem_ready immediate → EXEC shows alu_op=0000, rf_ra=1, rf_rb=2. WB shows rf_we=1, rf_wa=3. imem_req rises again 5 cycles after the first.
- LW 0x7423, dmem_ready after 3 wait cycles → dmem_req high for 4 cycles with dmem_we=0, b_sel=5 in MEM_ADDR. Then rf_we=1, rf_wd_sel=1, rf_wa=4.
- BZ 0x95FE:
  - alu_zero=1 → BR_TAKE with b_sel=3 and pc_we=1.
  - alu_zero=0 → FETCH right after BR_TEST, with only the PC_INC pc_we.
  - Repeat with BN 0xA5FE using alu_neg.
- LUI 0x55AB → alu_op=0101, alu_b_sel=4, then rf_we with rf_wa=5.
- Opcode 0xC000 → halted=1, illegal=1, no further imem_req over 20 cycles. Opcode 0xF000 → halted=1, illegal=0.
